// File: rtl/breath_sequencer_pkg.sv
// Shared definitions for the breathing-light sequencer: state encoding,
// palette size and the colour lookup used to drive the RGB pins.
package breath_sequencer_pkg;

  localparam int unsigned STATE_W    = 3;
  localparam int unsigned COLOR_W    = 3;
  localparam int unsigned RGB_W      = 3;
  localparam int unsigned NUM_COLORS = 6;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_RISE  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_FALL  = 3'd3,
    ST_GAP   = 3'd4,
    ST_SOLID = 3'd5
  } state_e;

  // Palette as {R,G,B}; indices beyond the palette map to dark.
  function automatic logic [RGB_W-1:0] color_lut(input logic [COLOR_W-1:0] idx);
    logic [RGB_W-1:0] rgb;
    case (idx)
      3'd0:    rgb = 3'b100;
      3'd1:    rgb = 3'b110;
      3'd2:    rgb = 3'b010;
      3'd3:    rgb = 3'b011;
      3'd4:    rgb = 3'b001;
      3'd5:    rgb = 3'b101;
      default: rgb = 3'b000;
    endcase
    return rgb;
  endfunction

  function automatic logic [COLOR_W-1:0] next_color(input logic [COLOR_W-1:0] idx);
    return (idx == COLOR_W'(NUM_COLORS - 1)) ? '0 : idx + COLOR_W'(1);
  endfunction

endpackage

// File: rtl/breath_sequencer_pwm_gen.sv
// Free-running PWM generator; the requested duty is only adopted at the
// counter wrap so every PWM period is a clean, unglitched period.
module breath_sequencer_pwm_gen #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk_div_i,
  input  logic                rst_i,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic                mask_c
);

  localparam logic [PWM_BITS-1:0] PWM_MAX = {PWM_BITS{1'b1}};

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] applied_q, applied_d;

  always_comb begin
    cnt_d     = cnt_q + PWM_BITS'(1);
    applied_d = applied_q;
    if (cnt_q == PWM_MAX) begin
      applied_d = duty_i;
    end
  end

  always_ff @(posedge clk_div_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      applied_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      applied_q <= applied_d;
    end
  end

  // Full duty must stay lit on the MAX count too, hence the explicit term.
  assign mask_c = (applied_q == PWM_MAX) || (cnt_q < applied_q);

endmodule

// File: rtl/breath_sequencer.sv
// Breathing-light sequencer: ramps PWM duty through RISE/HOLD/FALL/GAP,
// steps the palette after each breath and drives the registered RGB pins.
module breath_sequencer
  import breath_sequencer_pkg::*;
#(
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned STEP_TICKS = 122549,
  parameter int unsigned HOLD_STEPS = 64,
  parameter int unsigned GAP_STEPS  = 64
) (
  input  logic                clk_div_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                solid_i,
  output logic [RGB_W-1:0]    rgb4_o,
  output logic [PWM_BITS-1:0] duty_o,
  output logic [COLOR_W-1:0]  color_idx_o,
  output logic [STATE_W-1:0]  state_o,
  output logic                cycle_done_o
);

  localparam int unsigned STEP_W    = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int unsigned DWELL_MAX = (HOLD_STEPS > GAP_STEPS) ? HOLD_STEPS : GAP_STEPS;
  localparam int unsigned DWELL_W   = (DWELL_MAX > 1) ? $clog2(DWELL_MAX + 1) : 1;
  localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};

  state_e               state_q, state_d;
  logic [PWM_BITS-1:0]  duty_q, duty_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 done_q, done_d;
  logic [RGB_W-1:0]     rgb_q, rgb_d;

  logic                 step_tick_c;
  logic                 gap_exit_c;
  logic                 mask_c;
  logic [PWM_BITS-1:0]  duty_inc_c, duty_dec_c;
  logic [DWELL_W-1:0]   dwell_inc_c;

  assign step_tick_c = (step_q == STEP_W'(STEP_TICKS - 1));
  assign duty_inc_c  = duty_q + PWM_BITS'(1);
  assign duty_dec_c  = duty_q - PWM_BITS'(1);
  assign dwell_inc_c = dwell_q + DWELL_W'(1);

  breath_sequencer_pwm_gen #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm_gen (
    .clk_div_i(clk_div_i),
    .rst_i    (rst_i),
    .duty_i   (duty_q),
    .mask_c   (mask_c)
  );

  // Next-state, schedule counters, palette and output drive.
  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    color_d    = color_q;
    dwell_d    = dwell_q;
    done_d     = 1'b0;
    gap_exit_c = 1'b0;
    step_d     = step_tick_c ? '0 : step_q + STEP_W'(1);

    case (state_q)
      ST_IDLE: begin
        duty_d  = '0;
        color_d = '0;
        dwell_d = '0;
        step_d  = '0;
        if (en_i) begin
          if (solid_i) begin
            state_d = ST_SOLID;
            duty_d  = DUTY_MAX;
          end else begin
            state_d = ST_RISE;
          end
        end
      end
      ST_RISE: begin
        if (step_tick_c) begin
          duty_d = duty_inc_c;
          if (duty_inc_c == DUTY_MAX) begin
            state_d = (HOLD_STEPS == 0) ? ST_FALL : ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (step_tick_c) begin
          dwell_d = dwell_inc_c;
          if (dwell_inc_c == DWELL_W'(HOLD_STEPS)) begin
            state_d = ST_FALL;
            dwell_d = '0;
          end
        end
      end
      ST_FALL: begin
        if (step_tick_c) begin
          duty_d = duty_dec_c;
          if (duty_dec_c == '0) begin
            if (GAP_STEPS == 0) begin
              gap_exit_c = 1'b1;
            end else begin
              state_d = ST_GAP;
            end
          end
        end
      end
      ST_GAP: begin
        if (step_tick_c) begin
          dwell_d = dwell_inc_c;
          if (dwell_inc_c == DWELL_W'(GAP_STEPS)) begin
            gap_exit_c = 1'b1;
          end
        end
      end
      ST_SOLID: begin
        duty_d = DUTY_MAX;
        if (!solid_i) begin
          state_d = ST_FALL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // solid_i is only honoured here, so a breath always completes unchanged.
    if (gap_exit_c) begin
      done_d  = 1'b1;
      color_d = next_color(color_q);
      dwell_d = '0;
      if (solid_i) begin
        state_d = ST_SOLID;
        duty_d  = DUTY_MAX;
      end else begin
        state_d = ST_RISE;
      end
    end

    // Disable aborts immediately with no fade-out.
    if (!en_i) begin
      state_d = ST_IDLE;
      duty_d  = '0;
      color_d = '0;
      dwell_d = '0;
      done_d  = 1'b0;
    end

    if (state_d != state_q) begin
      step_d = '0;
    end

    rgb_d = (state_q == ST_IDLE) ? '0 : (color_lut(color_q) & {RGB_W{mask_c}});
  end

  always_ff @(posedge clk_div_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      color_q <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      done_q  <= 1'b0;
      rgb_q   <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      color_q <= color_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      done_q  <= done_d;
      rgb_q   <= rgb_d;
    end
  end

  assign rgb4_o       = rgb_q;
  assign duty_o       = duty_q;
  assign color_idx_o  = color_q;
  assign state_o      = state_q;
  assign cycle_done_o = done_q;

endmodule

// File: tb/tb_breath_sequencer.sv
// Scoreboard bench for breath_sequencer: two instances (with and without
// hold/gap dwell) share stimulus and are checked against a timeline model.
module tb_breath_sequencer;

  localparam int PB   = 3;
  localparam int MAXV = 7;
  localparam int ST   = 2;
  localparam int H_A  = 1;
  localparam int G_A  = 1;
  localparam int H_B  = 0;
  localparam int G_B  = 0;

  logic          clk = 1'b0;
  logic          rst, en, solid;
  logic [2:0]    rgb_a, rgb_b, col_a, col_b, st_a, st_b;
  logic [PB-1:0] duty_a, duty_b;
  logic          done_a, done_b;

  breath_sequencer #(.PWM_BITS(PB), .STEP_TICKS(ST), .HOLD_STEPS(H_A), .GAP_STEPS(G_A)) dut_a (
    .clk_div_i(clk), .rst_i(rst), .en_i(en), .solid_i(solid),
    .rgb4_o(rgb_a), .duty_o(duty_a), .color_idx_o(col_a), .state_o(st_a),
    .cycle_done_o(done_a));

  breath_sequencer #(.PWM_BITS(PB), .STEP_TICKS(ST), .HOLD_STEPS(H_B), .GAP_STEPS(G_B)) dut_b (
    .clk_div_i(clk), .rst_i(rst), .en_i(en), .solid_i(solid),
    .rgb4_o(rgb_b), .duty_o(duty_b), .color_idx_o(col_b), .state_o(st_b),
    .cycle_done_o(done_b));

  always #5 clk = ~clk;

  // mode: 0 idle, 1 breathing (t = clocks into the breath), 2 solid
  typedef struct {int mode; int t; int color; int done; int cnt; int applied; int rgb;} model_t;
  typedef struct {int state; int duty; int color; int done; int rgb;} obs_t;

  model_t ma, mb;
  obs_t   qa[$], qb[$];
  int     n_checks = 0;
  int     n_pass   = 0;
  int     lut[6]   = '{4, 6, 2, 3, 1, 5};
  bit     steady   = 1'b0;

  function automatic int m_duty(input model_t m, input int h);
    int rh, fe;
    rh = ST * (MAXV + h);
    fe = rh + ST * MAXV;
    if (m.mode == 0) return 0;
    if (m.mode == 2) return MAXV;
    if (m.t < ST * MAXV) return m.t / ST;
    if (m.t < rh) return MAXV;
    if (m.t < fe) return MAXV - (m.t - rh) / ST;
    return 0;
  endfunction

  function automatic int m_state(input model_t m, input int h);
    int rh, fe;
    rh = ST * (MAXV + h);
    fe = rh + ST * MAXV;
    if (m.mode == 0) return 0;
    if (m.mode == 2) return 5;
    if (m.t < ST * MAXV) return 1;
    if (m.t < rh) return 2;
    if (m.t < fe) return 3;
    return 4;
  endfunction

  function automatic model_t model_step(input model_t m, input bit r, input bit e, input bit s,
                                        input int h, input int g);
    model_t n;
    int     len;
    bit     mask;
    n    = m;
    len  = ST * (2 * MAXV + h + g);
    mask = (m.applied == MAXV) || (m.cnt < m.applied);
    n.done = 0;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    n.rgb = (m.mode == 0 || !mask) ? 0 : lut[m.color];
    n.cnt = (m.cnt + 1) % (MAXV + 1);
    if (m.cnt == MAXV) n.applied = m_duty(m, h);
    if (!e) begin
      n.mode  = 0;
      n.t     = 0;
      n.color = 0;
      return n;
    end
    case (m.mode)
      0: begin
        n.t    = 0;
        n.mode = s ? 2 : 1;
      end
      2: if (!s) begin
        n.mode = 1;
        n.t    = ST * (MAXV + h);
      end
      default: begin
        if (m.t + 1 == len) begin
          n.done  = 1;
          n.color = (m.color + 1) % 6;
          n.t     = 0;
          n.mode  = s ? 2 : 1;
        end else begin
          n.t = m.t + 1;
        end
      end
    endcase
    return n;
  endfunction

  function automatic obs_t to_obs(input model_t m, input int h);
    obs_t o;
    o.state = m_state(m, h);
    o.duty  = m_duty(m, h);
    o.color = m.color;
    o.done  = m.done;
    o.rgb   = m.rgb;
    return o;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
  endtask

  task automatic cycle(input bit r, input bit e, input bit s);
    @(negedge clk);
    rst   = r;
    en    = e;
    solid = s;
    ma = model_step(ma, r, e, s, H_A, G_A);
    mb = model_step(mb, r, e, s, H_B, G_B);
    qa.push_back(to_obs(ma, H_A));
    qb.push_back(to_obs(mb, H_B));
  endtask

  // Monitor: pops one expectation per clock and compares every output.
  initial begin : mon
    obs_t ea, eb;
    int   cyc, last_a, last_b;
    cyc = 0;
    last_a = 0;
    last_b = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (qa.size() > 0 && qb.size() > 0) begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        chk("state_a", int'(st_a), ea.state);
        chk("duty_a", int'(duty_a), ea.duty);
        chk("color_a", int'(col_a), ea.color);
        chk("done_a", int'(done_a), ea.done);
        chk("rgb_a", int'(rgb_a), ea.rgb);
        chk("state_b", int'(st_b), eb.state);
        chk("duty_b", int'(duty_b), eb.duty);
        chk("color_b", int'(col_b), eb.color);
        chk("done_b", int'(done_b), eb.done);
        chk("rgb_b", int'(rgb_b), eb.rgb);
      end
      if (!steady) begin
        last_a = 0;
        last_b = 0;
      end else begin
        if (done_a) begin
          if (last_a > 0) chk("breath_len_a", cyc - last_a, ST * (2 * MAXV + H_A + G_A));
          last_a = cyc;
        end
        if (done_b) begin
          if (last_b > 0) chk("breath_len_b", cyc - last_b, ST * (2 * MAXV + H_B + G_B));
          last_b = cyc;
        end
      end
    end
  end

  initial begin
    bit re, rs, rr;
    rst   = 1'b1;
    en    = 1'b0;
    solid = 1'b0;
    ma = '{default: 0};
    mb = '{default: 0};

    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0);

    // Six uninterrupted breaths walk the whole palette.
    steady = 1'b1;
    repeat (6 * 32 + 4) cycle(1'b0, 1'b1, 1'b0);
    steady = 1'b0;

    // Solid requested mid-breath, then released into FALL.
    repeat (70) cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 200; i++) begin
      if (m_state(ma, H_A) == 3 && m_duty(ma, H_A) == 4) break;
      cycle(1'b0, 1'b1, 1'b0);
    end

    // Abort mid-FALL, then restart from scratch.
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    repeat (40) cycle(1'b0, 1'b1, 1'b0);

    re = 1'b1;
    rs = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (re) begin
        if ($urandom_range(0, 149) == 0) re = 1'b0;
      end else if ($urandom_range(0, 4) == 0) begin
        re = 1'b1;
      end
      if ($urandom_range(0, 29) == 0) rs = ~rs;
      rr = ($urandom_range(0, 699) == 0);
      cycle(rr, re, rs);
    end

    for (int i = 0; i < 5 && qa.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    #2;
    chk("scoreboard_drain", qa.size() + qb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
